// File: rtl/pixel_fetch_ctrl.sv
// Pixel fetch controller: single-address fetches or whole-frame streams from a
// synchronous memory, with a tag pipeline realigning index/last flags to returning data.
module pixel_fetch_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int PIX_W   = 8,
  parameter int OUT_W   = 16,
  parameter int NUM_PIX = 784,
  parameter int RD_LAT  = 2,
  parameter int SHIFT   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              req,
  input  logic [ADDR_W-1:0] pixel_idx,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_dout,
  output logic              pix_valid,
  output logic [OUT_W-1:0]  pix_data,
  output logic [ADDR_W-1:0] pix_idx_out,
  output logic              frame_done,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIX - 1);
  localparam int EXT_W = PIX_W + SHIFT;

  typedef enum logic [1:0] {IDLE, SINGLE, STREAM} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [2:0]        cnt_reg, cnt_next;
  logic              issue, stream_issue, issue_last;

  logic [RD_LAT:0]   valid_pipe_reg, valid_pipe_next;
  logic [RD_LAT:0]   last_pipe_reg, last_pipe_next;
  logic [ADDR_W-1:0] idx_pipe_reg  [RD_LAT+1];
  logic [ADDR_W-1:0] idx_pipe_next [RD_LAT+1];
  logic              pipe_busy;

  logic              pix_valid_reg, frame_done_reg;
  logic [OUT_W-1:0]  pix_data_reg;
  logic [ADDR_W-1:0] pix_idx_reg;
  logic [EXT_W-1:0]  pix_shifted;
  logic [OUT_W-1:0]  pix_fmt;

  // The stream FSM returns to IDLE while reads are still in flight, so busy
  // also covers the draining tag pipeline.
  assign pipe_busy = |valid_pipe_reg;
  assign busy      = (state_reg != IDLE) || pipe_busy;

  always_comb begin
    state_next    = state_reg;
    mem_addr_next = mem_addr_reg;
    cnt_next      = cnt_reg;
    issue         = 1'b0;
    stream_issue  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (!pipe_busy) begin
          if (!mode && req) begin
            mem_addr_next = pixel_idx;
            issue         = 1'b1;
            cnt_next      = '0;
            state_next    = SINGLE;
          end else if (mode && start) begin
            mem_addr_next = '0;
            issue         = 1'b1;
            stream_issue  = 1'b1;
            state_next    = STREAM;
          end
        end
      end
      SINGLE: begin
        if (cnt_reg == 3'(RD_LAT)) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 3'd1;
        end
      end
      STREAM: begin
        if (mem_addr_reg == LAST_IDX) begin
          state_next = IDLE;
        end else begin
          mem_addr_next = mem_addr_reg + 1'b1;
          issue         = 1'b1;
          stream_issue  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    issue_last = stream_issue && (mem_addr_next == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      mem_addr_reg <= '0;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      mem_addr_reg <= mem_addr_next;
      cnt_reg      <= cnt_next;
    end
  end

  // Stage 0 is loaded alongside mem_addr; stage RD_LAT lines up with mem_dout.
  assign valid_pipe_next[0] = issue;
  assign last_pipe_next[0]  = issue_last;
  assign idx_pipe_next[0]   = issue ? mem_addr_next : idx_pipe_reg[0];

  for (genvar gi = 1; gi <= RD_LAT; gi++) begin : g_tag
    assign valid_pipe_next[gi] = valid_pipe_reg[gi-1];
    assign last_pipe_next[gi]  = last_pipe_reg[gi-1];
    assign idx_pipe_next[gi]   = idx_pipe_reg[gi-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_pipe_reg <= '0;
      last_pipe_reg  <= '0;
      for (int i = 0; i <= RD_LAT; i++) begin
        idx_pipe_reg[i] <= '0;
      end
    end else begin
      valid_pipe_reg <= valid_pipe_next;
      last_pipe_reg  <= last_pipe_next;
      idx_pipe_reg   <= idx_pipe_next;
    end
  end

  assign pix_shifted = EXT_W'(mem_dout) << SHIFT;

  if (EXT_W > OUT_W) begin : g_sat
    assign pix_fmt = (|pix_shifted[EXT_W-1:OUT_W]) ? '1 : pix_shifted[OUT_W-1:0];
  end else begin : g_nosat
    assign pix_fmt = OUT_W'(pix_shifted);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_valid_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      pix_data_reg   <= '0;
      pix_idx_reg    <= '0;
    end else begin
      pix_valid_reg  <= valid_pipe_reg[RD_LAT];
      frame_done_reg <= valid_pipe_reg[RD_LAT] && last_pipe_reg[RD_LAT];
      if (valid_pipe_reg[RD_LAT]) begin
        pix_data_reg <= pix_fmt;
        pix_idx_reg  <= idx_pipe_reg[RD_LAT];
      end
    end
  end

  assign mem_addr    = mem_addr_reg;
  assign pix_valid   = pix_valid_reg;
  assign frame_done  = frame_done_reg;
  assign pix_data    = pix_data_reg;
  assign pix_idx_out = pix_idx_reg;

endmodule

// File: tb/tb_pixel_fetch_ctrl.sv
// Bench for pixel_fetch_ctrl: two instances (SHIFT=0 and SHIFT=9) share stimulus,
// each reading its own latency-RD_LAT memory model holding mem[a] = a[7:0] ^ 8'h5A.
module tb_pixel_fetch_ctrl;
  localparam int ADDR_W  = 10;
  localparam int PIX_W   = 8;
  localparam int OUT_W   = 16;
  localparam int NUM_PIX = 784;
  localparam int RD_LAT  = 2;
  localparam int SAT_SH  = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode = 1'b0;
  logic req = 1'b0;
  logic start = 1'b0;
  logic [ADDR_W-1:0] pixel_idx = '0;

  logic [ADDR_W-1:0] mem_addr_a, mem_addr_b, pix_idx_a, pix_idx_b;
  logic [PIX_W-1:0]  mem_dout_a, mem_dout_b;
  logic [OUT_W-1:0]  pix_data_a, pix_data_b;
  logic pix_valid_a, pix_valid_b, frame_done_a, frame_done_b, busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pixel_fetch_ctrl #(.ADDR_W(ADDR_W), .PIX_W(PIX_W), .OUT_W(OUT_W), .NUM_PIX(NUM_PIX),
                     .RD_LAT(RD_LAT), .SHIFT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .mode(mode), .req(req), .pixel_idx(pixel_idx), .start(start),
    .mem_addr(mem_addr_a), .mem_dout(mem_dout_a), .pix_valid(pix_valid_a), .pix_data(pix_data_a),
    .pix_idx_out(pix_idx_a), .frame_done(frame_done_a), .busy(busy_a));

  pixel_fetch_ctrl #(.ADDR_W(ADDR_W), .PIX_W(PIX_W), .OUT_W(OUT_W), .NUM_PIX(NUM_PIX),
                     .RD_LAT(RD_LAT), .SHIFT(SAT_SH)) dut_b (
    .clk(clk), .rst_n(rst_n), .mode(mode), .req(req), .pixel_idx(pixel_idx), .start(start),
    .mem_addr(mem_addr_b), .mem_dout(mem_dout_b), .pix_valid(pix_valid_b), .pix_data(pix_data_b),
    .pix_idx_out(pix_idx_b), .frame_done(frame_done_b), .busy(busy_b));

  function automatic logic [PIX_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // Reference formatting: arithmetic shift, clamp to the largest OUT_W value.
  function automatic logic [OUT_W-1:0] fmt(input logic [PIX_W-1:0] v, input int sh);
    longint s;
    s = longint'(v) << sh;
    if (s > longint'((64'd1 << OUT_W) - 1)) return '1;
    return OUT_W'(s);
  endfunction

  logic [PIX_W-1:0] rd_a [RD_LAT];
  logic [PIX_W-1:0] rd_b [RD_LAT];
  always @(posedge clk) begin
    rd_a[0] <= mem_val(mem_addr_a);
    rd_b[0] <= mem_val(mem_addr_b);
    for (int i = 1; i < RD_LAT; i++) begin
      rd_a[i] <= rd_a[i-1];
      rd_b[i] <= rd_b[i-1];
    end
  end
  assign mem_dout_a = rd_a[RD_LAT-1];
  assign mem_dout_b = rd_b[RD_LAT-1];

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b1; start = 1'b1; mode = 1'b1; pixel_idx = ADDR_W'($urandom);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if ({pix_valid_a, frame_done_a, busy_a, pix_valid_b, frame_done_b, busy_b} !== 6'b0) begin
        errors++;
        $display("FAIL reset_flags: got va=%b fd=%b busy=%b vb=%b fdb=%b busyb=%b expected all 0",
                 pix_valid_a, frame_done_a, busy_a, pix_valid_b, frame_done_b, busy_b);
      end
      checks++;
      if (mem_addr_a !== '0 || pix_data_a !== '0 || pix_idx_a !== '0 || pix_data_b !== '0) begin
        errors++;
        $display("FAIL reset_data: got addr=%h data=%h idx=%h datab=%h expected 0",
                 mem_addr_a, pix_data_a, pix_idx_a, pix_data_b);
      end
    end
    $display("reset: held 3 cycles with req=1 start=1");
    rst_n = 1'b1; req = 1'b0; start = 1'b0;
  endtask

  task automatic test_single(input logic [ADDR_W-1:0] idx);
    logic [OUT_W-1:0] exp_a, exp_b;
    logic exp_v, exp_busy;
    exp_a = fmt(mem_val(idx), 0);
    exp_b = fmt(mem_val(idx), SAT_SH);
    mode = 1'b0; req = 1'b1; start = 1'($urandom % 2); pixel_idx = idx;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      exp_v = (j == RD_LAT + 2);
      exp_busy = (j <= RD_LAT + 1);
      checks++;
      if (pix_valid_a !== exp_v) begin
        errors++;
        $display("FAIL single_valid: step %0d got %b expected %b", j, pix_valid_a, exp_v);
      end
      checks++;
      if (busy_a !== exp_busy) begin
        errors++;
        $display("FAIL single_busy: step %0d got %b expected %b", j, busy_a, exp_busy);
      end
      checks++;
      if (frame_done_a !== 1'b0) begin
        errors++;
        $display("FAIL single_frame_done: step %0d got %b expected 0", j, frame_done_a);
      end
      if (j >= RD_LAT + 2) begin
        checks++;
        if (pix_idx_a !== idx) begin
          errors++;
          $display("FAIL single_idx: step %0d got %0d expected %0d", j, pix_idx_a, idx);
        end
        checks++;
        if (pix_data_a !== exp_a) begin
          errors++;
          $display("FAIL single_data: step %0d got %h expected %h", j, pix_data_a, exp_a);
        end
        checks++;
        if (pix_data_b !== exp_b) begin
          errors++;
          $display("FAIL single_sat_data: step %0d got %h expected %h", j, pix_data_b, exp_b);
        end
      end
      if (j == 1) begin
        req = 1'b0; start = 1'b0; pixel_idx = ADDR_W'($urandom);
      end
    end
    $display("single: idx=%0d data=%h sat_data=%h", idx, pix_data_a, pix_data_b);
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] hist [0:20];
    logic exp_v, exp_busy;
    mode = 1'b0; req = 1'b1; start = 1'b0;
    pixel_idx = ADDR_W'($urandom); hist[0] = pixel_idx;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      exp_v = (n % 4 == 0) && (n >= 4) && (n <= 16);
      exp_busy = (n % 4 != 0) && (n <= 15);
      checks++;
      if (pix_valid_a !== exp_v) begin
        errors++;
        $display("FAIL b2b_valid: cycle %0d got %b expected %b", n, pix_valid_a, exp_v);
      end
      checks++;
      if (busy_a !== exp_busy) begin
        errors++;
        $display("FAIL b2b_busy: cycle %0d got %b expected %b", n, busy_a, exp_busy);
      end
      if (exp_v) begin
        checks++;
        if (pix_idx_a !== hist[n-4]) begin
          errors++;
          $display("FAIL b2b_idx: cycle %0d got %0d expected %0d", n, pix_idx_a, hist[n-4]);
        end
        checks++;
        if (pix_data_a !== fmt(mem_val(hist[n-4]), 0)) begin
          errors++;
          $display("FAIL b2b_data: cycle %0d got %h expected %h", n, pix_data_a,
                   fmt(mem_val(hist[n-4]), 0));
        end
        $display("back_to_back: idx=%0d data=%h", pix_idx_a, pix_data_a);
      end
      pixel_idx = ADDR_W'($urandom); hist[n] = pixel_idx;
      if (n == 13) req = 1'b0;
    end
  endtask

  task automatic test_stream(input bit inject);
    logic exp_v, exp_busy, exp_fd;
    int exp_i;
    logic [ADDR_W-1:0] ei;
    mode = 1'b1; start = 1'b1; req = 1'($urandom % 2);
    for (int n = 1; n <= NUM_PIX + 8; n++) begin
      @(negedge clk);
      exp_v = (n >= 4) && (n <= NUM_PIX + 3);
      exp_busy = (n <= NUM_PIX + 2);
      exp_fd = (n == NUM_PIX + 3);
      checks++;
      if (pix_valid_a !== exp_v) begin
        errors++;
        $display("FAIL stream_valid: cycle %0d got %b expected %b", n, pix_valid_a, exp_v);
      end
      checks++;
      if (busy_a !== exp_busy) begin
        errors++;
        $display("FAIL stream_busy: cycle %0d got %b expected %b", n, busy_a, exp_busy);
      end
      checks++;
      if (frame_done_a !== exp_fd) begin
        errors++;
        $display("FAIL stream_frame_done: cycle %0d got %b expected %b", n, frame_done_a, exp_fd);
      end
      if (n >= 4) begin
        exp_i = (n <= NUM_PIX + 3) ? n - 4 : NUM_PIX - 1;
        ei = ADDR_W'(exp_i);
        checks++;
        if (pix_idx_a !== ei) begin
          errors++;
          $display("FAIL stream_idx: cycle %0d got %0d expected %0d", n, pix_idx_a, ei);
        end
        checks++;
        if (pix_data_a !== fmt(mem_val(ei), 0) || pix_data_b !== fmt(mem_val(ei), SAT_SH)) begin
          errors++;
          $display("FAIL stream_data: cycle %0d got %h/%h expected %h/%h", n, pix_data_a,
                   pix_data_b, fmt(mem_val(ei), 0), fmt(mem_val(ei), SAT_SH));
        end
      end
      if (inject && n >= 10 && n <= 700) begin
        req = 1'($urandom % 2); start = 1'($urandom % 2); mode = 1'($urandom % 2);
        pixel_idx = ADDR_W'($urandom);
      end else begin
        req = 1'b0; start = 1'b0; mode = 1'b1;
      end
    end
    $display("stream: %0d pixels, inject=%0d, last idx=%0d", NUM_PIX, inject, pix_idx_a);
  endtask

  task automatic test_mid_reset();
    mode = 1'b1; start = 1'b1; req = 1'b0;
    for (int n = 1; n <= 104; n++) begin
      @(negedge clk);
      checks++;
      if (pix_valid_a !== (n >= 4) || frame_done_a !== 1'b0) begin
        errors++;
        $display("FAIL midrst_pre: cycle %0d got v=%b fd=%b expected v=%b fd=0", n,
                 pix_valid_a, frame_done_a, (n >= 4));
      end
      if (n >= 4) begin
        checks++;
        if (pix_idx_a !== ADDR_W'(n - 4)) begin
          errors++;
          $display("FAIL midrst_idx: cycle %0d got %0d expected %0d", n, pix_idx_a, n - 4);
        end
      end
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (pix_valid_a !== 1'b0 || busy_a !== 1'b0 || mem_addr_a !== '0 || pix_idx_a !== '0) begin
      errors++;
      $display("FAIL midrst_clear: got v=%b busy=%b addr=%0d idx=%0d expected all 0",
               pix_valid_a, busy_a, mem_addr_a, pix_idx_a);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (pix_valid_a !== 1'b0 || frame_done_a !== 1'b0 || busy_a !== 1'b0) begin
        errors++;
        $display("FAIL midrst_quiet: cycle %0d got v=%b fd=%b busy=%b expected 0", k,
                 pix_valid_a, frame_done_a, busy_a);
      end
    end
    $display("mid_stream_reset: reset at idx 100, pipeline quiet afterwards");
    test_stream(1'b0);
  endtask

  initial begin
    test_reset();
    test_single(ADDR_W'(5));
    test_single(ADDR_W'(37));
    test_single(ADDR_W'(165));
    repeat (5) test_single(ADDR_W'($urandom));
    test_back_to_back();
    test_stream(1'b1);
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pixel_fetch_ctrl.md
PIXEL_FETCH_CTRL -- requirements
Module: pixel_fetch_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10: pixel address width.
REQ-002 Parameter PIX_W, default 8: stored pixel width.
REQ-003 Parameter OUT_W, default 16: output word width, with OUT_W >= PIX_W.
REQ-004 Parameter NUM_PIX, default 784: pixels per frame, range 1..2^ADDR_W.
REQ-005 Parameter RD_LAT, default 2: memory read latency in clocks, range 1..4.
REQ-006 Parameter SHIFT, default 0: left shift applied to each pixel on output, range 0..OUT_W-1.
REQ-007 Port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-008 Port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-009 Port mode, input, 1 bit: 0 = single-pixel fetch, 1 = frame stream; sampled only in IDLE.
REQ-010 Port req, input, 1 bit: single-fetch request, level-sampled.
REQ-011 Port pixel_idx, input, ADDR_W bits: address for a single fetch.
REQ-012 Port start, input, 1 bit: starts a frame stream.
REQ-013 Port mem_addr, output, ADDR_W bits: registered read address to the external synchronous memory.
REQ-014 Port mem_dout, input, PIX_W bits: memory read data, valid RD_LAT clocks after mem_addr.
REQ-015 Port pix_valid, output, 1 bit: one-cycle qualifier for pix_data and pix_idx_out.
REQ-016 Port pix_data, output, OUT_W bits: formatted pixel.
REQ-017 Port pix_idx_out, output, ADDR_W bits: address that produced pix_data.
REQ-018 Port frame_done, output, 1 bit: pulses with the last pixel of a stream.
REQ-019 Port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-020 The state machine SHALL have three states:
- IDLE
- SINGLE: one read outstanding
- STREAM: issuing addresses
REQ-021 In IDLE, mode=0 and req=1 SHALL register mem_addr<=pixel_idx and go to SINGLE.
REQ-022 In IDLE, mode=1 and start=1 SHALL register mem_addr<=0 and go to STREAM.
REQ-023 In IDLE, req and start together SHALL be resolved by mode alone.
REQ-024 For a single fetch, pix_valid SHALL assert exactly RD_LAT+1 edges after the edge that sampled req, for one cycle; the FSM returns to IDLE on that same edge.
REQ-025 A req held high SHALL produce back-to-back fetches, each separated by one IDLE cycle.
REQ-026 In STREAM, mem_addr SHALL increment by 1 every cycle up to NUM_PIX-1, then the FSM returns to IDLE.
REQ-027 A stream SHALL produce exactly NUM_PIX consecutive pix_valid cycles, with pix_idx_out 0..NUM_PIX-1 in order and no gaps.
REQ-028 frame_done SHALL be high only in the cycle pix_valid carries index NUM_PIX-1 of a stream; it is never high in single mode.
REQ-029 busy SHALL remain high until the last pix_valid of the operation has been output.
REQ-030 A new operation SHALL be accepted only after busy has fallen.
REQ-031 req and start SHALL be ignored while busy is high.
REQ-032 A valid/index tag pipeline of depth RD_LAT+1 SHALL align pix_idx_out and frame_done with the returning data.
REQ-033 Formatting: zero-extend mem_dout to PIX_W+SHIFT bits, then shift left by SHIFT.
REQ-034 If any set bit falls above bit OUT_W-1 after the shift, pix_data SHALL saturate to all ones; otherwise it takes the low OUT_W bits.
REQ-035 pix_data and pix_idx_out SHALL hold their last values while pix_valid is low.
REQ-036 No backpressure SHALL exist; the downstream consumer accepts one pixel per cycle.

Reset
REQ-037 While rst_n=0 at an edge, the block SHALL go to IDLE and drive mem_addr, pix_data, pix_idx_out, pix_valid, frame_done and busy to 0.
REQ-038 On reset, the tag pipeline SHALL be cleared.
REQ-039 Reset mid-operation SHALL discard all in-flight reads; no pix_valid or frame_done follows them.
REQ-040 The first operation after rst_n returns to 1 SHALL start from IDLE.

Verification (RD_LAT=2; memory model mem[a]=a[7:0]^8'h5A)
REQ-041 Reset: rst_n=0 for 3 cycles with req=1 and start=1 -> every output 0, busy 0.
REQ-042 Single fetch: mode=0, req=1 for one cycle, pixel_idx=5.
- Required: pix_valid high exactly 3 edges later for 1 cycle, pix_data=16'h005F, pix_idx_out=5.
- busy falls in the same cycle as pix_valid.
REQ-043 Stream: mode=1, start pulse, NUM_PIX=784.
- Required: 784 contiguous pix_valid cycles, indices 0..783.
- frame_done asserted only with index 783; busy 0 on the following cycle.
REQ-044 Ignore while busy: req pulse and start pulse during a stream -> stream output unchanged, no extra pix_valid.
REQ-045 Saturation with SHIFT=9: mem_dout=8'h7F -> 16'hFE00; mem_dout=8'hFF -> 16'hFFFF.
REQ-046 Mid-stream reset: rst_n=0 for 1 cycle at index 100 -> no pix_valid or frame_done afterwards; next start restarts at index 0.
